nav_motion_sequencer: RTL and testbench
=======================================

Name: nav_motion_sequencer

Overview:
Parametrised two-motor motion sequencer for the navigation system. It accepts one motion command at a time over a valid/ready handshake (STOP, STRAIGHT, TURN_RIGHT, TURN_LEFT) and drives both motor controllers' direction and power fields until the command completes. Adds wall-alignment trim, a watchdog timeout, abort and error recovery, and a manual button override. It sits between the path planner and the motor controller drivers; MC1 is the right side, MC2 the left.

Parameters:
DIST_W, 8, width of all distance sensor inputs
PWR_W, 3, width of each motor power field
STOP_DIST, 12, STRAIGHT completes when DIST_FRONT <= STOP_DIST
ALIGN_TOL, 2, side-sensor difference allowed before trim is applied
TURN_TOL, 10, turn completes when |DIST_FRONT - captured target| <= TURN_TOL
TO_W, 24, width of the timeout counter
TIMEOUT_CYC, 24'd10000000, maximum number of EXEC cycles before error
RAMP_DIV, 16, cycles per soft-start power step (used only with the optional feature)

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
MANUAL  in  1  1 = button control, FSM bypassed
BTN  in  5  manual buttons, one-hot
PWR_SEL  in  PWR_W  base power level
CMD  in  2  00 STOP, 01 STRAIGHT, 10 TURN_RIGHT, 11 TURN_LEFT
CMD_VALID  in  1  command offered
CMD_READY  out  1  command accepted when VALID & READY
ABORT  in  1  force error during execution
DIST_FRONT  in  DIST_W  front range
DIST_SIDE_FRONT  in  DIST_W  right-side front range
DIST_SIDE_BACK  in  DIST_W  right-side rear range
MC1_DIR, MC2_DIR  out  2  00 forward, 01 neutral, 10 reverse
MC1_PWR, MC2_PWR  out  PWR_W  motor power
RUN_FLAG  out  2  00 idle, 01 executing, 10 complete, 11 error
DONE  out  1  one-cycle completion pulse

Behaviour:
- Clocking and reset: one clock, CLK. RST_N is asynchronous and active-low.
- Reset state: FSM in IDLE; MCx_DIR = 01; MCx_PWR = 0; RUN_FLAG = 00; DONE = 0.
- All motor outputs are registered, with 1-cycle latency from any input.
- CMD_READY is combinational: it is 1 when the state is IDLE or ERROR and MANUAL = 0.
- IDLE:
  - Outputs are neutral, power 0.
  - On accept, latch CMD, load the timeout counter with TIMEOUT_CYC, and capture TGT = DIST_SIDE_FRONT (used by turns). Go to EXEC.
  - An accepted STOP goes directly to COMPLETE.
- EXEC (RUN_FLAG = 01):
  - The timeout counter decrements once per cycle. If it reaches 0 before completion, go to ERROR.
  - ABORT = 1 goes to ERROR. ABORT takes priority over completion in the same cycle.
  - STRAIGHT:
    - Both directions 00.
    - Base power = PWR_SEL.
    - If DIST_SIDE_FRONT > DIST_SIDE_BACK + ALIGN_TOL: MC1_PWR = base+1, saturating at all-ones.
    - If DIST_SIDE_BACK > DIST_SIDE_FRONT + ALIGN_TOL: MC2_PWR = base+1, saturating.
    - Otherwise both motors get base.
    - Comparisons use DIST_W+1 bits, so there is no wrap.
    - Completes when DIST_FRONT <= STOP_DIST.
  - TURN_RIGHT: MC1 10, MC2 00. TURN_LEFT: MC1 00, MC2 10. Both motors at base power.
  - A turn completes when the absolute difference of DIST_FRONT and TGT is <= TURN_TOL. The difference is computed unsigned, larger minus smaller.
  - On completion, the outputs go neutral with power 0 in the same registered update.
- COMPLETE: lasts exactly one cycle with DONE = 1 and RUN_FLAG = 10, then returns to IDLE.
- ERROR (RUN_FLAG = 11):
  - Outputs are neutral, power 0.
  - An accepted STOP returns to IDLE.
  - Any other accepted command is consumed and dropped; the state stays ERROR.
- Manual override:
  - MANUAL = 1 forces the FSM to IDLE on the next edge. Any in-flight command is abandoned with no DONE.
  - Button mapping:
    - BTN 00001: MC1 01, MC2 00 (forward-right).
    - 00010: both 10.
    - 00100: both 00.
    - 01000: MC1 00, MC2 01 (forward-left).
    - 10000: MC1 10, MC2 00 (spin right).
    - Any other value: neutral.
  - Power is PWR_SEL on both motors for a driving button, 0 when neutral.
- Reset mid-operation: returns immediately to reset values. A latched command is discarded.

Optional Feature:
NAV_SOFT_START_EN
- When defined: on each EXEC entry a ramp register starts at 0 and increments once every RAMP_DIV cycles.
- While ramping, the power actually output is min(computed power, ramp), including trim.
- The ramp is cleared on leaving EXEC and does not apply in manual mode.
- When undefined: the computed power is applied on the first EXEC cycle; the RAMP_DIV parameter is unused.

Test Plan:
- Reset, RST_N low mid-STRAIGHT -> immediately MCx_DIR = 01, PWR = 0, RUN_FLAG = 00, CMD_READY = 1 after release.
- STRAIGHT, PWR_SEL = 3, SF = 40, SB = 35, DIST_FRONT falling 50->12 -> MC1_PWR = 4, MC2_PWR = 3 while driving; neutral and one DONE pulse after front hits 12; RUN_FLAG 01->10->00.
- PWR_SEL = 7 with trim active -> MC1_PWR saturates at 7, no wrap to 0.
- TURN_RIGHT accepted with SF = 60, DIST_FRONT sweeping 20->55 -> MC1 10, MC2 00 until front = 50; then complete with DONE.
- TIMEOUT_CYC = 100, STRAIGHT with DIST_FRONT = 200 -> RUN_FLAG = 11 after 100 EXEC cycles; TURN_LEFT offered -> accepted but dropped, still 11; STOP -> IDLE.
- MANUAL raised mid-turn, BTN = 00100, PWR_SEL = 2 -> both 00 at power 2, CMD_READY = 0, no DONE; BTN = 00101 -> neutral.

Source files
------------

// File: rtl/nav_motion_sequencer.sv
// Two-motor motion sequencer: takes one command over valid/ready and drives MC1 (right) and MC2 (left).
// Optional soft-start power ramp is enabled with `define NAV_SOFT_START_EN.
module nav_motion_sequencer #(
  parameter int unsigned     DIST_W      = 8,
  parameter int unsigned     PWR_W       = 3,
  parameter int unsigned     STOP_DIST   = 12,
  parameter int unsigned     ALIGN_TOL   = 2,
  parameter int unsigned     TURN_TOL    = 10,
  parameter int unsigned     TO_W        = 24,
  parameter logic [TO_W-1:0] TIMEOUT_CYC = TO_W'(10000000),
  parameter int unsigned     RAMP_DIV    = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              MANUAL,
  input  logic [4:0]        BTN,
  input  logic [PWR_W-1:0]  PWR_SEL,
  input  logic [1:0]        CMD,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              ABORT,
  input  logic [DIST_W-1:0] DIST_FRONT,
  input  logic [DIST_W-1:0] DIST_SIDE_FRONT,
  input  logic [DIST_W-1:0] DIST_SIDE_BACK,
  output logic [1:0]        MC1_DIR,
  output logic [1:0]        MC2_DIR,
  output logic [PWR_W-1:0]  MC1_PWR,
  output logic [PWR_W-1:0]  MC2_PWR,
  output logic [1:0]        RUN_FLAG,
  output logic              DONE
);

  localparam int unsigned DX_W = DIST_W + 1;

  localparam logic [1:0] DIR_FWD = 2'b00;
  localparam logic [1:0] DIR_NEU = 2'b01;
  localparam logic [1:0] DIR_REV = 2'b10;

  localparam logic [1:0] CMD_STOP     = 2'b00;
  localparam logic [1:0] CMD_STRAIGHT = 2'b01;
  localparam logic [1:0] CMD_RIGHT    = 2'b10;
  localparam logic [1:0] CMD_LEFT     = 2'b11;

  localparam logic [1:0] RF_IDLE = 2'b00;
  localparam logic [1:0] RF_EXEC = 2'b01;
  localparam logic [1:0] RF_DONE = 2'b10;
  localparam logic [1:0] RF_ERR  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_COMPLETE, S_ERROR} state_t;

  if (RAMP_DIV == 0) begin : g_bad_ramp_div
    $error("RAMP_DIV must be at least 1");
  end

  state_t            state;
  logic [1:0]        cmd_q;
  logic [DIST_W-1:0] tgt_q;
  logic [TO_W-1:0]   to_q;

  logic [DX_W-1:0]   sf_x, sb_x;
  logic              trim_r, trim_l;
  logic [PWR_W-1:0]  pwr_inc;
  logic [DIST_W-1:0] turn_diff;
  logic              cmd_done;
  logic [1:0]        drv1_dir, drv2_dir;
  logic [PWR_W-1:0]  drv1_pwr, drv2_pwr;
  logic [PWR_W-1:0]  out1_pwr, out2_pwr;
  logic [1:0]        man1_dir, man2_dir;
  logic [PWR_W-1:0]  man_pwr;

  assign CMD_READY = ((state == S_IDLE) || (state == S_ERROR)) && !MANUAL;

  // Drive values and completion test for the latched command
  always_comb begin
    sf_x      = {1'b0, DIST_SIDE_FRONT};
    sb_x      = {1'b0, DIST_SIDE_BACK};
    trim_r    = sf_x > (sb_x + DX_W'(ALIGN_TOL));
    trim_l    = sb_x > (sf_x + DX_W'(ALIGN_TOL));
    pwr_inc   = (&PWR_SEL) ? PWR_SEL : PWR_SEL + PWR_W'(1);
    turn_diff = (DIST_FRONT >= tgt_q) ? DIST_FRONT - tgt_q : tgt_q - DIST_FRONT;
    drv1_dir  = DIR_FWD;
    drv2_dir  = DIR_FWD;
    drv1_pwr  = PWR_SEL;
    drv2_pwr  = PWR_SEL;
    cmd_done  = 1'b0;
    case (cmd_q)
      CMD_STRAIGHT: begin
        if (trim_r)      drv1_pwr = pwr_inc;
        else if (trim_l) drv2_pwr = pwr_inc;
        cmd_done = DIST_FRONT <= DIST_W'(STOP_DIST);
      end
      CMD_RIGHT: begin
        drv1_dir = DIR_REV;
        cmd_done = turn_diff <= DIST_W'(TURN_TOL);
      end
      CMD_LEFT: begin
        drv2_dir = DIR_REV;
        cmd_done = turn_diff <= DIST_W'(TURN_TOL);
      end
      default: cmd_done = 1'b1;
    endcase
  end

  // Button override mapping
  always_comb begin
    man1_dir = DIR_NEU;
    man2_dir = DIR_NEU;
    man_pwr  = '0;
    case (BTN)
      5'b00001: begin man2_dir = DIR_FWD; man_pwr = PWR_SEL; end
      5'b00010: begin man1_dir = DIR_REV; man2_dir = DIR_REV; man_pwr = PWR_SEL; end
      5'b00100: begin man1_dir = DIR_FWD; man2_dir = DIR_FWD; man_pwr = PWR_SEL; end
      5'b01000: begin man1_dir = DIR_FWD; man_pwr = PWR_SEL; end
      5'b10000: begin man1_dir = DIR_REV; man2_dir = DIR_FWD; man_pwr = PWR_SEL; end
      default: ;
    endcase
  end

`ifdef NAV_SOFT_START_EN
  localparam int unsigned RAMP_CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  logic [RAMP_CW-1:0] div_q;
  logic [PWR_W-1:0]   ramp_q;

  // Ramp restarts from zero on every EXEC entry and caps drive power
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_q  <= '0;
      ramp_q <= '0;
    end else if (state != S_EXEC || MANUAL) begin
      div_q  <= '0;
      ramp_q <= '0;
    end else if (div_q == RAMP_CW'(RAMP_DIV - 1)) begin
      div_q  <= '0;
      ramp_q <= (&ramp_q) ? ramp_q : ramp_q + PWR_W'(1);
    end else begin
      div_q <= div_q + RAMP_CW'(1);
    end
  end

  assign out1_pwr = (drv1_pwr > ramp_q) ? ramp_q : drv1_pwr;
  assign out2_pwr = (drv2_pwr > ramp_q) ? ramp_q : drv2_pwr;
`else
  assign out1_pwr = drv1_pwr;
  assign out2_pwr = drv2_pwr;
`endif

  // Sequencer state and registered motor/status outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= S_IDLE;
      cmd_q    <= CMD_STOP;
      tgt_q    <= '0;
      to_q     <= '0;
      MC1_DIR  <= DIR_NEU;
      MC2_DIR  <= DIR_NEU;
      MC1_PWR  <= '0;
      MC2_PWR  <= '0;
      RUN_FLAG <= RF_IDLE;
      DONE     <= 1'b0;
    end else begin
      MC1_DIR <= DIR_NEU;
      MC2_DIR <= DIR_NEU;
      MC1_PWR <= '0;
      MC2_PWR <= '0;
      DONE    <= 1'b0;
      if (MANUAL) begin
        state    <= S_IDLE;
        RUN_FLAG <= RF_IDLE;
        MC1_DIR  <= man1_dir;
        MC2_DIR  <= man2_dir;
        MC1_PWR  <= man_pwr;
        MC2_PWR  <= man_pwr;
      end else begin
        case (state)
          S_IDLE: begin
            RUN_FLAG <= RF_IDLE;
            if (CMD_VALID) begin
              cmd_q <= CMD;
              to_q  <= TIMEOUT_CYC;
              tgt_q <= DIST_SIDE_FRONT;
              if (CMD == CMD_STOP) begin
                state    <= S_COMPLETE;
                RUN_FLAG <= RF_DONE;
                DONE     <= 1'b1;
              end else begin
                state    <= S_EXEC;
                RUN_FLAG <= RF_EXEC;
              end
            end
          end
          S_EXEC: begin
            if (ABORT) begin
              state    <= S_ERROR;
              RUN_FLAG <= RF_ERR;
            end else if (cmd_done) begin
              state    <= S_COMPLETE;
              RUN_FLAG <= RF_DONE;
              DONE     <= 1'b1;
            end else if (to_q <= TO_W'(1)) begin
              state    <= S_ERROR;
              RUN_FLAG <= RF_ERR;
            end else begin
              to_q    <= to_q - TO_W'(1);
              MC1_DIR <= drv1_dir;
              MC2_DIR <= drv2_dir;
              MC1_PWR <= out1_pwr;
              MC2_PWR <= out2_pwr;
            end
          end
          S_COMPLETE: begin
            state    <= S_IDLE;
            RUN_FLAG <= RF_IDLE;
          end
          default: begin
            RUN_FLAG <= RF_ERR;
            // Non-STOP commands are consumed here and dropped
            if (CMD_VALID && CMD == CMD_STOP) begin
              state    <= S_IDLE;
              RUN_FLAG <= RF_IDLE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nav_motion_sequencer.sv
// Directed self-checking bench for nav_motion_sequencer (timeout shortened to 100 cycles).
module tb_nav_motion_sequencer;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       MANUAL;
  logic [4:0] BTN;
  logic [2:0] PWR_SEL;
  logic [1:0] CMD;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic       ABORT;
  logic [7:0] DIST_FRONT;
  logic [7:0] DIST_SIDE_FRONT;
  logic [7:0] DIST_SIDE_BACK;
  logic [1:0] MC1_DIR, MC2_DIR;
  logic [2:0] MC1_PWR, MC2_PWR;
  logic [1:0] RUN_FLAG;
  logic       DONE;

  int checks = 0;
  int errors = 0;

  nav_motion_sequencer #(.TIMEOUT_CYC(24'd100)) dut (
    .CLK(CLK), .RST_N(RST_N), .MANUAL(MANUAL), .BTN(BTN), .PWR_SEL(PWR_SEL),
    .CMD(CMD), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .ABORT(ABORT),
    .DIST_FRONT(DIST_FRONT), .DIST_SIDE_FRONT(DIST_SIDE_FRONT), .DIST_SIDE_BACK(DIST_SIDE_BACK),
    .MC1_DIR(MC1_DIR), .MC2_DIR(MC2_DIR), .MC1_PWR(MC1_PWR), .MC2_PWR(MC2_PWR),
    .RUN_FLAG(RUN_FLAG), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_motor(input string tag, input logic [1:0] d1, input logic [1:0] d2,
                           input logic [2:0] p1, input logic [2:0] p2);
    chk({tag, ".mc1_dir"}, 32'(MC1_DIR), 32'(d1));
    chk({tag, ".mc2_dir"}, 32'(MC2_DIR), 32'(d2));
    chk({tag, ".mc1_pwr"}, 32'(MC1_PWR), 32'(p1));
    chk({tag, ".mc2_pwr"}, 32'(MC2_PWR), 32'(p2));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0; MANUAL = 1'b0; BTN = 5'b0; PWR_SEL = 3'd3; CMD = 2'b00; CMD_VALID = 1'b0;
    ABORT = 1'b0; DIST_FRONT = 8'd200; DIST_SIDE_FRONT = 8'd40; DIST_SIDE_BACK = 8'd35;
    tick(); tick();
    chk_motor("reset", 2'b01, 2'b01, 3'd0, 3'd0);
    chk("reset.run_flag", 32'(RUN_FLAG), 32'd0);
    chk("reset.done", 32'(DONE), 32'd0);
    chk("reset.ready", 32'(CMD_READY), 32'd1);
    RST_N = 1'b1;
    tick();

    // STRAIGHT with right-side trim, front falling to the stop distance
    CMD = 2'b01; CMD_VALID = 1'b1; DIST_FRONT = 8'd50;
    tick();
    CMD_VALID = 1'b0;
    chk("str.accept.run_flag", 32'(RUN_FLAG), 32'd1);
    chk("str.accept.ready", 32'(CMD_READY), 32'd0);
    chk_motor("str.first", 2'b01, 2'b01, 3'd0, 3'd0);
    DIST_FRONT = 8'd40; tick();
    chk_motor("str.trim40", 2'b00, 2'b00, 3'd4, 3'd3);
    DIST_FRONT = 8'd13; tick();
    chk_motor("str.trim13", 2'b00, 2'b00, 3'd4, 3'd3);
    chk("str.nodone", 32'(DONE), 32'd0);
    DIST_FRONT = 8'd12; tick();
    chk_motor("str.complete", 2'b01, 2'b01, 3'd0, 3'd0);
    chk("str.done", 32'(DONE), 32'd1);
    chk("str.run_flag_c", 32'(RUN_FLAG), 32'd2);
    tick();
    chk("str.done_pulse", 32'(DONE), 32'd0);
    chk("str.run_flag_i", 32'(RUN_FLAG), 32'd0);

    // Saturation, left trim, in-tolerance, then abort and recovery
    PWR_SEL = 3'd7; DIST_FRONT = 8'd50; CMD = 2'b01; CMD_VALID = 1'b1;
    tick();
    CMD_VALID = 1'b0;
    tick();
    chk_motor("sat", 2'b00, 2'b00, 3'd7, 3'd7);
    PWR_SEL = 3'd3; DIST_SIDE_FRONT = 8'd30; DIST_SIDE_BACK = 8'd40; tick();
    chk_motor("trim_left", 2'b00, 2'b00, 3'd3, 3'd4);
    DIST_SIDE_FRONT = 8'd40; DIST_SIDE_BACK = 8'd38; tick();
    chk_motor("in_tol", 2'b00, 2'b00, 3'd3, 3'd3);
    ABORT = 1'b1; DIST_FRONT = 8'd5; tick();
    ABORT = 1'b0;
    chk("abort.run_flag", 32'(RUN_FLAG), 32'd3);
    chk("abort.done", 32'(DONE), 32'd0);
    chk_motor("abort", 2'b01, 2'b01, 3'd0, 3'd0);
    CMD = 2'b00; CMD_VALID = 1'b1; tick();
    CMD_VALID = 1'b0;
    chk("abort.stop.run_flag", 32'(RUN_FLAG), 32'd0);

    // TURN_RIGHT with target captured from side-front at accept
    DIST_SIDE_FRONT = 8'd60; DIST_FRONT = 8'd20; CMD = 2'b10; CMD_VALID = 1'b1;
    tick();
    CMD_VALID = 1'b0; DIST_SIDE_FRONT = 8'd0;
    for (int f = 25; f <= 45; f += 5) begin
      DIST_FRONT = 8'(f); tick();
      chk_motor($sformatf("turn_r.f%0d", f), 2'b10, 2'b00, 3'd3, 3'd3);
    end
    DIST_FRONT = 8'd50; tick();
    chk_motor("turn_r.complete", 2'b01, 2'b01, 3'd0, 3'd0);
    chk("turn_r.done", 32'(DONE), 32'd1);
    tick();
    chk("turn_r.run_flag_i", 32'(RUN_FLAG), 32'd0);

    // Timeout after 100 EXEC cycles, dropped command in ERROR, STOP recovery
    DIST_SIDE_FRONT = 8'd40; DIST_SIDE_BACK = 8'd40; DIST_FRONT = 8'd200;
    CMD = 2'b01; CMD_VALID = 1'b1;
    tick();
    CMD_VALID = 1'b0;
    repeat (99) tick();
    chk("to.pre.run_flag", 32'(RUN_FLAG), 32'd1);
    tick();
    chk("to.run_flag", 32'(RUN_FLAG), 32'd3);
    chk_motor("to", 2'b01, 2'b01, 3'd0, 3'd0);
    CMD = 2'b11; CMD_VALID = 1'b1;
    chk("err.ready", 32'(CMD_READY), 32'd1);
    tick();
    CMD_VALID = 1'b0;
    tick();
    chk("err.drop.run_flag", 32'(RUN_FLAG), 32'd3);
    chk_motor("err.drop", 2'b01, 2'b01, 3'd0, 3'd0);
    CMD = 2'b00; CMD_VALID = 1'b1; tick();
    CMD_VALID = 1'b0;
    chk("err.stop.run_flag", 32'(RUN_FLAG), 32'd0);

    // STOP from IDLE completes immediately
    CMD = 2'b00; CMD_VALID = 1'b1; tick();
    CMD_VALID = 1'b0;
    chk("stop.done", 32'(DONE), 32'd1);
    chk("stop.run_flag", 32'(RUN_FLAG), 32'd2);
    tick();
    chk("stop.run_flag_i", 32'(RUN_FLAG), 32'd0);

    // Manual override mid-turn
    DIST_SIDE_FRONT = 8'd60; DIST_FRONT = 8'd20; CMD = 2'b11; CMD_VALID = 1'b1;
    tick();
    CMD_VALID = 1'b0;
    tick();
    chk_motor("turn_l", 2'b00, 2'b10, 3'd3, 3'd3);
    MANUAL = 1'b1; BTN = 5'b00100; PWR_SEL = 3'd2;
    #1;
    chk("man.ready", 32'(CMD_READY), 32'd0);
    tick();
    chk_motor("man.fwd", 2'b00, 2'b00, 3'd2, 3'd2);
    chk("man.run_flag", 32'(RUN_FLAG), 32'd0);
    chk("man.done", 32'(DONE), 32'd0);
    BTN = 5'b00101; tick();
    chk_motor("man.bad", 2'b01, 2'b01, 3'd0, 3'd0);
    BTN = 5'b10000; tick();
    chk_motor("man.spin", 2'b10, 2'b00, 3'd2, 3'd2);
    BTN = 5'b00001; tick();
    chk_motor("man.fr", 2'b01, 2'b00, 3'd2, 3'd2);
    BTN = 5'b00010; tick();
    chk_motor("man.rev", 2'b10, 2'b10, 3'd2, 3'd2);
    BTN = 5'b01000; tick();
    chk_motor("man.fl", 2'b00, 2'b01, 3'd2, 3'd2);
    MANUAL = 1'b0; BTN = 5'b0; tick();
    chk_motor("man.exit", 2'b01, 2'b01, 3'd0, 3'd0);
    chk("man.exit.ready", 32'(CMD_READY), 32'd1);
    chk("man.exit.done", 32'(DONE), 32'd0);
    chk("man.exit.run_flag", 32'(RUN_FLAG), 32'd0);

    // Asynchronous reset mid-STRAIGHT
    PWR_SEL = 3'd3; DIST_FRONT = 8'd50; DIST_SIDE_FRONT = 8'd40; DIST_SIDE_BACK = 8'd35;
    CMD = 2'b01; CMD_VALID = 1'b1; tick();
    CMD_VALID = 1'b0; tick();
    chk_motor("rst.pre", 2'b00, 2'b00, 3'd4, 3'd3);
    #2 RST_N = 1'b0;
    #1;
    chk_motor("rst.async", 2'b01, 2'b01, 3'd0, 3'd0);
    chk("rst.async.run_flag", 32'(RUN_FLAG), 32'd0);
    tick();
    RST_N = 1'b1;
    tick();
    chk("rst.rel.ready", 32'(CMD_READY), 32'd1);
    chk("rst.rel.run_flag", 32'(RUN_FLAG), 32'd0);
    chk_motor("rst.rel", 2'b01, 2'b01, 3'd0, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
